// File: rtl/snes_joy_pkg.sv
// Shared constants for the SNES controller-port emulator: button indices,
// frame geometry and reset values.
package snes_joy_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BTN_W   = 12;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned TURBO_W = 8;

  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  localparam logic                RST_BTN   = 1'b1;
  localparam logic [FRAME_W-1:0]  RST_SHIFT = '1;
  localparam logic [TURBO_W-1:0]  RST_TURBO = '0;

  // Serial frame as the console reads it, LSB first: buttons then signature.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [ID_W-1:0]  id,
                                                     input logic [BTN_W-1:0] eff);
    return {id, eff};
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// One raw active-low button: multi-flop synchroniser followed by a
// counter-based debouncer (or a straight wire when DEBOUNCE_W is 0).
module joy_debounce
  import snes_joy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_btn_n,
  output logic o_stable_n
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= {SYNC_STAGES{RST_BTN}};
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_n};
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_W == 0) begin : g_bypass
      assign o_stable_n = w_synced;
    end else begin : g_debounce
      logic                  r_stable;
      logic [DEBOUNCE_W-1:0] r_cnt;

      // Accept a new level only after it has disagreed with stable for 2^W cycles.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_stable <= RST_BTN;
          r_cnt    <= '0;
        end else if (w_synced == r_stable) begin
          r_cnt <= '0;
        end else if (&r_cnt) begin
          r_stable <= w_synced;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + DEBOUNCE_W'(1);
        end
      end

      assign o_stable_n = r_stable;
    end
  endgenerate

endmodule

// File: rtl/snes_joy_serializer.sv
// SNES controller-port emulator: debounced buttons with autofire are latched
// on joy_strb and shifted out LSB-first on each port's joy_clk.
module snes_joy_serializer
  import snes_joy_pkg::*;
#(
  parameter int unsigned     NUM_PORTS    = 2,
  parameter int unsigned     SYNC_STAGES  = 2,
  parameter int unsigned     DEBOUNCE_W   = 16,
  parameter int unsigned     TURBO_PERIOD = 4,
  parameter logic            FILL_BIT     = 1'b1,
  parameter logic [ID_W-1:0] ID_BITS      = 4'b1111
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_PORTS*BTN_W-1:0] buttons_n,
  input  logic [NUM_PORTS*BTN_W-1:0] turbo_en,
  input  logic                       joy_strb,
  input  logic [NUM_PORTS-1:0]       joy_clk,
  output logic [NUM_PORTS-1:0]       joy_di,
  output logic                       poll_tick,
  output logic                       turbo_phase
);

  localparam int unsigned NB = NUM_PORTS * BTN_W;

  logic [NB-1:0]        w_stable;
  logic [NB-1:0]        w_eff;
  logic                 w_strb_rise;
  logic                 r_strb_d;
  logic                 r_poll_tick;
  logic                 r_phase;
  logic [TURBO_W-1:0]   r_turbo_cnt;
  logic [NUM_PORTS-1:0] r_clk_d;
  logic [NUM_PORTS-1:0] r_clk_rise;
  logic [FRAME_W-1:0]   r_shift [NUM_PORTS];

  generate
    for (genvar i = 0; i < int'(NB); i++) begin : g_btn
      joy_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_debounce (
        .clk        (clk),
        .resetn     (resetn),
        .i_btn_n    (buttons_n[i]),
        .o_stable_n (w_stable[i])
      );
    end
  endgenerate

  assign w_strb_rise = joy_strb & ~r_strb_d;
  assign w_eff       = w_stable | (turbo_en & {NB{r_phase}});

  // Poll counter paces autofire; poll_tick marks the strobe falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_strb_d    <= 1'b0;
      r_poll_tick <= 1'b0;
      r_phase     <= 1'b0;
      r_turbo_cnt <= RST_TURBO;
    end else begin
      r_strb_d    <= joy_strb;
      r_poll_tick <= r_strb_d & ~joy_strb;
      if (w_strb_rise) begin
        if (r_turbo_cnt == TURBO_W'(TURBO_PERIOD - 1)) begin
          r_turbo_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_turbo_cnt <= r_turbo_cnt + TURBO_W'(1);
        end
      end
    end
  end

  // Clock edges seen while the strobe is high are discarded so the latch wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_d    <= '0;
      r_clk_rise <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) r_shift[p] <= RST_SHIFT;
    end else begin
      r_clk_d    <= joy_clk;
      r_clk_rise <= joy_clk & ~r_clk_d & {NUM_PORTS{~joy_strb}};
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (joy_strb)
          r_shift[p] <= build_frame(ID_BITS, w_eff[p*BTN_W +: BTN_W]);
        else if (r_clk_rise[p])
          r_shift[p] <= {FILL_BIT, r_shift[p][FRAME_W-1:1]};
      end
    end
  end

  always_comb begin
    joy_di = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) joy_di[p] = r_shift[p][0];
  end

  assign poll_tick   = r_poll_tick;
  assign turbo_phase = r_phase;

endmodule

// File: tb/tb_snes_joy_serializer.sv
// Bench for snes_joy_serializer: a bypassed-debounce and a 4-bit-debounce
// instance share stimulus and are checked against a frame/poll-count model.
module tb_snes_joy_serializer;

  localparam int unsigned TP   = 2;
  localparam logic        FILL = 1'b1;

  logic        clk;
  logic        resetn;
  logic [23:0] btn_n;
  logic [23:0] ten;
  logic        joy_strb;
  logic [1:0]  joy_clk;
  logic [1:0]  di_a, di_b;
  logic        pt_a, pt_b, ph_a, ph_b;

  int checks = 0;
  int errors = 0;
  int nrise  = 0;

  snes_joy_serializer #(
    .NUM_PORTS(2), .SYNC_STAGES(2), .DEBOUNCE_W(0), .TURBO_PERIOD(TP),
    .FILL_BIT(FILL), .ID_BITS(4'b1111)
  ) u_dut_a (
    .clk(clk), .resetn(resetn), .buttons_n(btn_n), .turbo_en(ten),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_di(di_a),
    .poll_tick(pt_a), .turbo_phase(ph_a)
  );

  snes_joy_serializer #(
    .NUM_PORTS(2), .SYNC_STAGES(2), .DEBOUNCE_W(4), .TURBO_PERIOD(TP),
    .FILL_BIT(FILL), .ID_BITS(4'b1111)
  ) u_dut_b (
    .clk(clk), .resetn(resetn), .buttons_n(btn_n), .turbo_en(ten),
    .joy_strb(joy_strb), .joy_clk(joy_clk), .joy_di(di_b),
    .poll_tick(pt_b), .turbo_phase(ph_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame the console should read: signature, then buttons forced released by turbo.
  function automatic logic [15:0] model_frame(input int port, input bit ph);
    logic [11:0] b, t;
    b = btn_n[port*12 +: 12];
    t = ten[port*12 +: 12];
    return {4'b1111, b | (t & {12{ph}})};
  endfunction

  function automatic logic fbit(input logic [15:0] f, input int i);
    return (i < 16) ? f[i] : FILL;
  endfunction

  // One-cycle strobe, then nshift clock pulses on both ports, checking every bit.
  task automatic do_poll(input string tag, input int nshift,
                         output logic [15:0] f0, output logic [15:0] f1);
    bit ph;
    ph = ((nrise / TP) % 2) == 1;
    f0 = model_frame(0, ph);
    f1 = model_frame(1, ph);
    joy_strb = 1'b1;
    tick();
    nrise++;
    chk({tag, "_bit0"}, 32'({di_b, di_a}), 32'({f1[0], f0[0], f1[0], f0[0]}));
    chk({tag, "_phase"}, 32'({ph_b, ph_a}), ((nrise / TP) % 2 == 1) ? 32'd3 : 32'd0);
    joy_strb = 1'b0;
    tick();
    chk({tag, "_tick"}, 32'({pt_b, pt_a}), 32'd3);
    for (int i = 1; i <= nshift; i++) begin
      joy_clk = 2'b11;
      tick();
      if (i == 1) chk({tag, "_tick_end"}, 32'({pt_b, pt_a}), 32'd0);
      joy_clk = 2'b00;
      tick();
      chk($sformatf("%s_bit%0d", tag, i), 32'({di_b, di_a}),
          32'({fbit(f1, i), fbit(f0, i), fbit(f1, i), fbit(f0, i)}));
    end
  endtask

  initial begin
    logic [15:0] f0, f1;
    bit          ph;
    logic        a_exp, b_exp;

    resetn   = 1'b0;
    btn_n    = '1;
    ten      = '0;
    joy_strb = 1'b0;
    joy_clk  = 2'b00;

    // Reset state, held while joy_clk toggles.
    repeat (3) tick();
    chk("rst_di", 32'({di_b, di_a}), 32'hF);
    chk("rst_phase", 32'({ph_b, ph_a}), 32'd0);
    chk("rst_tick", 32'({pt_b, pt_a}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      joy_clk = 2'b11; tick();
      joy_clk = 2'b00; tick();
      chk($sformatf("rst_hold%0d", i), 32'({di_b, di_a}), 32'hF);
    end
    resetn = 1'b1;

    // Turbo on A, A held: pressed,pressed,released,released,...
    btn_n[8] = 1'b0; btn_n[20] = 1'b0;
    ten[8]   = 1'b1; ten[20]   = 1'b1;
    repeat (30) tick();
    for (int k = 0; k < 8; k++) begin
      do_poll($sformatf("turbo%0d", k), 8, f0, f1);
      chk($sformatf("turbo_a%0d", k), 32'({di_b, di_a}), ((k % 4) < 2) ? 32'h0 : 32'hF);
    end
    ten = '0;

    // B on port 0, Right on port 1, then a 17th clock reads FILL.
    btn_n = '1;
    btn_n[0] = 1'b0; btn_n[12 + 7] = 1'b0;
    repeat (30) tick();
    do_poll("dir", 17, f0, f1);
    chk("dir_frame0", 32'(f0), 32'hFFFE);
    chk("dir_frame1", 32'(f1), 32'hFF7F);

    // 10-cycle glitch on Start: seen by the bypassed instance only.
    btn_n = '1;
    repeat (30) tick();
    btn_n[3] = 1'b0;
    repeat (10) tick();
    joy_strb = 1'b1; btn_n[3] = 1'b1;
    tick();
    nrise++;
    joy_strb = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      joy_clk = 2'b11; tick();
      joy_clk = 2'b00; tick();
    end
    chk("glitch_bypass", 32'(di_a), 32'h2);
    chk("glitch_debounce", 32'(di_b), 32'h3);
    repeat (30) tick();
    do_poll("post_glitch", 16, f0, f1);

    // Held B under continuous strobe: visible after 2 (bypass) / 18 (debounce) cycles.
    joy_strb = 1'b1;
    tick();
    nrise++;
    btn_n[0] = 1'b0; btn_n[12] = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      a_exp = (k >= 3)  ? 1'b0 : 1'b1;
      b_exp = (k >= 19) ? 1'b0 : 1'b1;
      chk($sformatf("latency_k%0d", k), 32'({di_b, di_a}), 32'({b_exp, b_exp, a_exp, a_exp}));
    end
    joy_strb = 1'b0;
    tick();

    // Strobe collides with a clock rise: reload, no shift.
    btn_n = '1;
    btn_n[0] = 1'b0; btn_n[5] = 1'b0; btn_n[12 + 1] = 1'b0;
    repeat (30) tick();
    do_poll("pre_col", 5, f0, f1);
    ph = ((nrise / TP) % 2) == 1;
    f0 = model_frame(0, ph);
    f1 = model_frame(1, ph);
    joy_strb = 1'b1; joy_clk = 2'b11;
    tick();
    nrise++;
    chk("col_load", 32'({di_b, di_a}), 32'({f1[0], f0[0], f1[0], f0[0]}));
    joy_strb = 1'b0;
    tick();
    joy_clk = 2'b00;
    tick();
    chk("col_noshift", 32'({di_b, di_a}), 32'({f1[0], f0[0], f1[0], f0[0]}));
    joy_clk = 2'b11; tick();
    joy_clk = 2'b00; tick();
    chk("col_next", 32'({di_b, di_a}), 32'({f1[1], f0[1], f1[1], f0[1]}));

    // Mid-frame reset after 5 shifts, then a fresh full frame.
    do_poll("pre_rst", 5, f0, f1);
    #2 resetn = 1'b0;
    #1;
    chk("mrst_di", 32'({di_b, di_a}), 32'hF);
    chk("mrst_phase", 32'({ph_b, ph_a}), 32'd0);
    chk("mrst_tick", 32'({pt_b, pt_a}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      joy_clk = 2'b11; tick();
      joy_clk = 2'b00; tick();
      chk($sformatf("mrst_hold%0d", i), 32'({di_b, di_a}), 32'hF);
    end
    resetn = 1'b1;
    nrise  = 0;
    repeat (30) tick();
    do_poll("post_rst", 16, f0, f1);

    // Random buttons and turbo enables against the model.
    for (int r = 0; r < 8; r++) begin
      btn_n = 24'($urandom);
      ten   = 24'($urandom);
      repeat (25) tick();
      do_poll($sformatf("rnd%0d", r), 16, f0, f1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
